fwd_prop_seq: RTL and testbench

FWD_PROP_SEQ -- requirements
Module: fwd_prop_seq

---
 rtl/fwd_prop_seq_pkg.sv | 38 +++
 rtl/fwd_prop_seq_phase_timer.sv | 30 +++
 rtl/fwd_prop_seq.sv | 175 +++++++++++++++++
 tb/tb_fwd_prop_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_prop_seq_pkg.sv
// Shared definitions for the forward-pass sequencer and its datapath:
// phase codes driven on ctrl, field widths and the default step wrap point.
package fwd_prop_seq_pkg;

  localparam int CTRL_W  = 4;
  localparam int ST_W    = 4;
  localparam int STEP_W  = 4;
  localparam int DWELL_W = 4;

  localparam logic [STEP_W-1:0] MAX_STEP_DEF = 4'd15;

  // Datapath phase codes; the sequencer state register is driven onto ctrl
  // unchanged, so these encodings are also the state encoding.
  typedef enum logic [CTRL_W-1:0] {
    PH_IDLE   = 4'b0000,
    PH_LOAD   = 4'b0001,
    PH_ACC2   = 4'b0010,
    PH_ACT2   = 4'b0011,
    PH_ACC3   = 4'b0100,
    PH_ACT3   = 4'b0101,
    PH_STORE  = 4'b0110,
    PH_UPDATE = 4'b0111,
    PH_DONE   = 4'b1000
  } phase_e;

  // Episode step advance: wraps from max_step back to 1, never to 0,
  // because step 0 means "datapath frozen".
  function automatic logic [STEP_W-1:0] step_next(
    input logic [STEP_W-1:0] cur,
    input logic [STEP_W-1:0] max_step
  );
    if (cur >= max_step) begin
      return 4'd1;
    end
    return cur + 4'd1;
  endfunction

endpackage

// File: rtl/fwd_prop_seq_phase_timer.sv
// Dwell timer shared by every phase of the sequencer.  The counter restarts
// at 0 when a phase is entered and o_expire flags the last cycle of a phase
// that lasts i_len cycles (i_len >= 1, so a phase is never shorter than one
// cycle).
module phase_timer
  import fwd_prop_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [DWELL_W-1:0] i_len,
  output logic               o_expire
);

  logic [DWELL_W-1:0] r_cnt;

  // Count cycles spent in the current phase; i_load marks phase entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DWELL_W'(1);
    end
  end

  assign o_expire = (r_cnt == (i_len - DWELL_W'(1)));

endmodule

// File: rtl/fwd_prop_seq.sv
// Forward-pass sequencer: walks the network datapath through
// LOAD, ACC2, ACT2, ACC3, ACT3, STORE, optional UPDATE and DONE, keeps the
// episode step counter and holds the captured environment state index.
//
// Handshake: start is a request qualified by ready.  A pass is accepted on a
// rising edge where start=1 and ready=1; ready is high only while the
// sequencer sits in IDLE.  A start seen while ready=0 is dropped, never
// queued, so a requester must keep start high until it sees ready.
module fwd_prop_seq
  import fwd_prop_seq_pkg::*;
#(
  parameter int unsigned       ACC2_CYC = 1,
  parameter int unsigned       ACT_LAT  = 2,
  parameter int unsigned       ACC3_CYC = 1,
  parameter logic [STEP_W-1:0] MAX_STEP = MAX_STEP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ST_W-1:0]   st_in,
  input  logic              upd_en,
  input  logic              abort,
  input  logic              step_clr,
  output logic              ready,
  output logic [CTRL_W-1:0] ctrl,
  output logic [STEP_W-1:0] step,
  output logic [ST_W-1:0]   st,
  output logic              done,
  output logic              acc_clr
);

  localparam logic [DWELL_W-1:0] LEN_ONE  = DWELL_W'(1);
  localparam logic [DWELL_W-1:0] LEN_ACC2 = DWELL_W'(ACC2_CYC);
  localparam logic [DWELL_W-1:0] LEN_ACT  = DWELL_W'(ACT_LAT);
  localparam logic [DWELL_W-1:0] LEN_ACC3 = DWELL_W'(ACC3_CYC);

  phase_e             r_state;
  phase_e             w_next;
  logic [STEP_W-1:0]  r_step;
  logic [ST_W-1:0]    r_st;
  logic               r_upd;
  logic [DWELL_W-1:0] w_len;
  logic               w_load;
  logic               w_expire;
  logic               w_accept;
  logic               w_abort;

  assign w_accept = start && (r_state == PH_IDLE);
  // Abort only means something while a pass is in flight.
  assign w_abort  = abort && (r_state != PH_IDLE);

  // Dwell length of the phase currently held; single-cycle phases use 1.
  always_comb begin
    w_len = LEN_ONE;
    case (r_state)
      PH_ACC2: w_len = LEN_ACC2;
      PH_ACT2: w_len = LEN_ACT;
      PH_ACC3: w_len = LEN_ACC3;
      PH_ACT3: w_len = LEN_ACT;
      default: w_len = LEN_ONE;
    endcase
  end

  // Next phase: advance when the dwell timer expires; abort overrides all.
  always_comb begin
    w_next = r_state;
    case (r_state)
      PH_IDLE: begin
        if (w_accept) begin
          w_next = PH_LOAD;
        end
      end
      PH_LOAD: begin
        if (w_expire) begin
          w_next = PH_ACC2;
        end
      end
      PH_ACC2: begin
        if (w_expire) begin
          w_next = PH_ACT2;
        end
      end
      PH_ACT2: begin
        if (w_expire) begin
          w_next = PH_ACC3;
        end
      end
      PH_ACC3: begin
        if (w_expire) begin
          w_next = PH_ACT3;
        end
      end
      PH_ACT3: begin
        if (w_expire) begin
          w_next = PH_STORE;
        end
      end
      PH_STORE: begin
        if (w_expire) begin
          w_next = r_upd ? PH_UPDATE : PH_DONE;
        end
      end
      PH_UPDATE: begin
        if (w_expire) begin
          w_next = PH_DONE;
        end
      end
      PH_DONE: begin
        if (w_expire) begin
          w_next = PH_IDLE;
        end
      end
      default: w_next = PH_IDLE;
    endcase
    if (w_abort) begin
      w_next = PH_IDLE;
    end
  end

  // Restart the dwell count on every phase change; idling keeps it at 0.
  assign w_load = (w_next != r_state) || (w_next == PH_IDLE);

  phase_timer u_phase_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_len    (w_len),
    .o_expire (w_expire)
  );

  // Phase register; it is also the ctrl output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= PH_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture the pass arguments on accept; they stay put until the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_st  <= '0;
      r_upd <= 1'b0;
    end else if (w_accept) begin
      r_st  <= st_in;
      r_upd <= upd_en;
    end
  end

  // Episode step: clear beats everything, an aborted STORE does not count,
  // a pass accepted at step 0 starts the episode at 1 so ACC phases never
  // run with the datapath frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_step <= '0;
    end else if (step_clr) begin
      r_step <= '0;
    end else if (w_abort) begin
      r_step <= r_step;
    end else if (w_accept && (r_step == '0)) begin
      r_step <= 4'd1;
    end else if (r_state == PH_STORE) begin
      r_step <= step_next(r_step, MAX_STEP);
    end
  end

  assign ctrl    = r_state;
  assign ready   = (r_state == PH_IDLE);
  assign done    = (r_state == PH_DONE);
  assign acc_clr = (r_state == PH_LOAD);
  assign step    = r_step;
  assign st      = r_st;

endmodule

// File: tb/tb_fwd_prop_seq.sv
// Bench for fwd_prop_seq: a pass-level reference model turns every issued
// pass into the list of per-cycle outputs it must produce; a monitor pops
// that list whenever the sequencer is busy.
module tb_fwd_prop_seq;

  localparam int ACC2_CYC = 1;
  localparam int ACT_LAT  = 2;
  localparam int ACC3_CYC = 1;
  localparam int MAX_STEP = 15;
  localparam int EW       = 15;

  // Positions inside a full pass (LOAD is index 0).
  localparam int ACT2_IDX  = 1 + ACC2_CYC;
  localparam int ACC3_IDX  = 1 + ACC2_CYC + ACT_LAT;
  localparam int STORE_IDX = 1 + ACC2_CYC + ACT_LAT + ACC3_CYC + ACT_LAT;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] st_in;
  logic       upd_en;
  logic       abort;
  logic       step_clr;
  logic       ready;
  logic [3:0] ctrl;
  logic [3:0] step;
  logic [3:0] st;
  logic       done;
  logic       acc_clr;

  int total;
  int bad;

  // expected entry: {ctrl, st, step, done, acc_clr, ready}
  logic [EW-1:0] exp_q[$];
  logic [3:0]    plist[$];
  logic [3:0]    m_step;
  logic [3:0]    m_st;

  fwd_prop_seq #(
    .ACC2_CYC (ACC2_CYC),
    .ACT_LAT  (ACT_LAT),
    .ACC3_CYC (ACC3_CYC),
    .MAX_STEP (4'(MAX_STEP))
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .st_in    (st_in),
    .upd_en   (upd_en),
    .abort    (abort),
    .step_clr (step_clr),
    .ready    (ready),
    .ctrl     (ctrl),
    .step     (step),
    .st       (st),
    .done     (done),
    .acc_clr  (acc_clr)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Phase sequence of one complete pass, straight from the phase table.
  task automatic build_list(input logic u);
    plist.delete();
    plist.push_back(4'd1);
    for (int i = 0; i < ACC2_CYC; i++) plist.push_back(4'd2);
    for (int i = 0; i < ACT_LAT; i++)  plist.push_back(4'd3);
    for (int i = 0; i < ACC3_CYC; i++) plist.push_back(4'd4);
    for (int i = 0; i < ACT_LAT; i++)  plist.push_back(4'd5);
    plist.push_back(4'd6);
    if (u) plist.push_back(4'd7);
    plist.push_back(4'd8);
  endtask

  function automatic logic [3:0] wrap_inc(input logic [3:0] v);
    if (int'(v) >= MAX_STEP) return 4'd1;
    return v + 4'd1;
  endfunction

  // One pass: idle gap, accept, then the busy cycles.  abort_at / clr_at /
  // rst_at give the pass cycle (0 = LOAD) in which that input is raised;
  // -1 leaves it off.  Mid-pass start/st_in/upd_en are random noise.
  task automatic run_pass(input logic [3:0] s, input logic u, input int gap,
                          input int abort_at, input int clr_at, input int rst_at);
    int         k;
    int         last;
    logic [3:0] cur;
    start = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
    build_list(u);
    k = plist.size();
    if (rst_at >= 0) k = rst_at;
    else if (abort_at >= 0) k = abort_at + 1;
    start  = 1'b1;
    st_in  = s;
    upd_en = u;
    @(posedge clk);
    // reference model for the accepted pass
    cur  = (m_step == 4'd0) ? 4'd1 : m_step;
    m_st = s;
    for (int c = 0; c < k; c++) begin
      exp_q.push_back({plist[c], s, cur, plist[c] == 4'd8, plist[c] == 4'd1, 1'b0});
      if (c == clr_at) cur = 4'd0;
      else if (plist[c] == 4'd6 && c != abort_at) cur = wrap_inc(cur);
    end
    m_step = cur;
    #1;
    last = (rst_at >= 0) ? rst_at : k - 1;
    for (int c = 0; c <= last; c++) begin
      start    = 1'($urandom_range(0, 1));
      st_in    = 4'($urandom_range(0, 15));
      upd_en   = 1'($urandom_range(0, 1));
      abort    = (c == abort_at);
      step_clr = (c == clr_at);
      if (c == rst_at) begin
        start = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check("rst_ctrl", {4'd0, ctrl}, 8'd0);
        check("rst_step", {4'd0, step}, 8'd0);
        check("rst_st", {4'd0, st}, 8'd0);
        check("rst_ready", {7'd0, ready}, 8'd1);
        check("rst_done", {7'd0, done}, 8'd0);
        check("rst_acc_clr", {7'd0, acc_clr}, 8'd0);
        m_step = 4'd0;
        m_st   = 4'd0;
        @(posedge clk);
        #1;
        rst = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    abort    = 1'b0;
    step_clr = 1'b0;
    start    = 1'b0;
    check("queue_drain", 8'(exp_q.size()), 8'd0);
    exp_q.delete();
    check("idle_step", {4'd0, step}, {4'd0, m_step});
    check("idle_st", {4'd0, st}, {4'd0, m_st});
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    a = {ctrl, st, step, done, acc_clr, ready};
    total++;
    if (ctrl != 4'd0) begin
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_busy got ctrl=%0d st=%0d step=%0d t=%0t", ctrl, st, step, $time);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL pass_cycle got ctrl=%0d st=%0d step=%0d done=%0b acc_clr=%0b ready=%0b want ctrl=%0d st=%0d step=%0d done=%0b acc_clr=%0b ready=%0b t=%0t",
                   ctrl, st, step, done, acc_clr, ready,
                   e[14:11], e[10:7], e[6:3], e[2], e[1], e[0], $time);
        end
      end
    end else if ({ready, done, acc_clr} !== 3'b100) begin
      bad++;
      $display("FAIL idle_flags got ready=%0b done=%0b acc_clr=%0b want ready=1 done=0 acc_clr=0 t=%0t",
               ready, done, acc_clr, $time);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    int len;
    int ab;
    int cl;
    logic u;
    total    = 0;
    bad      = 0;
    m_step   = 4'd0;
    m_st     = 4'd0;
    rst      = 1'b0;
    start    = 1'b0;
    st_in    = 4'd0;
    upd_en   = 1'b0;
    abort    = 1'b0;
    step_clr = 1'b0;
    #1;
    check("reset_ctrl", {4'd0, ctrl}, 8'd0);
    check("reset_step", {4'd0, step}, 8'd0);
    check("reset_st", {4'd0, st}, 8'd0);
    check("reset_ready", {7'd0, ready}, 8'd1);
    check("reset_done", {7'd0, done}, 8'd0);
    check("reset_acc_clr", {7'd0, acc_clr}, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // basic pass, state 5, no update
    run_pass(4'd5, 1'b0, 1, -1, -1, -1);
    // update phase requested on accept (upd_en noise afterwards)
    run_pass(4'd2, 1'b1, 0, -1, -1, -1);
    // abort in the first ACT2 cycle, then start right away
    run_pass(4'd7, 1'b0, 0, ACT2_IDX, -1, -1);
    run_pass(4'd3, 1'b0, 0, -1, -1, -1);

    // bring step to 7 at STORE, then clear it in that STORE cycle
    guard = 0;
    while (m_step != 4'd7 && guard < 20) begin
      run_pass(4'($urandom_range(0, 8)), 1'($urandom_range(0, 1)), 0, -1, -1, -1);
      guard++;
    end
    check("step_reaches_7", {4'd0, step}, 8'd7);
    run_pass(4'd4, 1'b0, 0, -1, STORE_IDX, -1);

    // reset asserted in the middle of ACC3
    run_pass(4'd6, 1'b1, 0, -1, -1, ACC3_IDX);

    // 16 back-to-back passes from step 0: wrap must go to 1
    for (int p = 0; p < 16; p++) begin
      run_pass(4'($urandom_range(0, 8)), 1'b0, 0, -1, -1, -1);
      check("step_not_zero", {7'd0, step == 4'd0}, 8'd0);
    end

    // randomized passes
    for (int p = 0; p < 40; p++) begin
      u   = 1'($urandom_range(0, 1));
      len = 1 + ACC2_CYC + ACT_LAT + ACC3_CYC + ACT_LAT + 2 + int'(u);
      ab  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      cl  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      run_pass(4'($urandom_range(0, 8)), u, int'($urandom_range(0, 3)), ab, cl, -1);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
